// File: rtl/gcode_seq_gen_pkg.sv
// Shared types for the Gray-code sequence generator: FSM state encoding and
// direction constants sampled from the 'up' input.
package gcode_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/gcode_seq_gen_enc.sv
// Purpose: binary to reflected Gray code conversion.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module bin2gcode_enc #(
    parameter int p_nbits = 4
) (
    input  logic [p_nbits-1:0] in_,
    output logic [p_nbits-1:0] out
);

    assign out = in_ ^ (in_ >> 1);

endmodule

// File: rtl/gcode_seq_gen.sv
// Purpose: on start, walk a binary count up/down and stream its Gray code.
// Latency: first code valid one cycle after start; one code per accepted transfer.
// Backpressure: val/rdy; count and code hold while out_rdy is low.
module gcode_seq_gen
    import gcode_seq_gen_pkg::*;
#(
    parameter int p_nbits = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               up,
    input  logic [p_nbits-1:0] start_bin,
    input  logic [p_nbits-1:0] len_m1,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out,
    output logic               busy,
    output logic               done
);

    localparam logic [p_nbits-1:0] ONE = {{(p_nbits-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [p_nbits-1:0] bin_q, bin_d;
    logic [p_nbits-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic [p_nbits-1:0] bin_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            rem_q   <= '0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    // Modular step; wrap-around falls out of the fixed register width.
    assign bin_step = (dir_q == DIR_DN) ? (bin_q - ONE) : (bin_q + ONE);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        out_val = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = start_bin;
                    rem_d   = len_m1;
                    dir_d   = up;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_val = 1'b1;
                busy    = 1'b1;
                if (out_rdy) begin
                    // Final code keeps bin so out holds it through DONE and IDLE.
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bin_d = bin_step;
                        rem_d = rem_q - ONE;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    bin2gcode_enc #(
        .p_nbits(p_nbits)
    ) u_enc (
        .in_ (bin_q),
        .out (out)
    );

endmodule

// File: tb/tb_gcode_seq_gen.sv
// Self-checking bench for gcode_seq_gen: queue-based reference of expected codes
// compared every cycle, plus literal sequences for the directed cases.
module tb_gcode_seq_gen;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         up = 1'b1;
    logic [N-1:0] start_bin = '0;
    logic [N-1:0] len_m1 = '0;
    logic         out_rdy = 1'b0;
    logic         out_val;
    logic [N-1:0] out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    gcode_seq_gen #(.p_nbits(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .up        (up),
        .start_bin (start_bin),
        .len_m1    (len_m1),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    int compared = 0;
    int mismatched = 0;
    bit chk_en = 0;
    int done_cnt = 0;

    // Reference: codes still to be emitted, last code shown, pending done pulse.
    int mq[$];
    int last_code = 0;
    bit done_exp = 0;
    int mb;
    int cap[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            last_code = 0;
            done_exp  = 0;
        end else if (done_exp) begin
            done_exp = 0;
        end else if (mq.size() > 0) begin
            if (out_rdy) begin
                last_code = mq.pop_front();
                if (mq.size() == 0) done_exp = 1;
            end
        end else if (start) begin
            for (int i = 0; i <= int'(len_m1); i++) begin
                mb = up ? (int'(start_bin) + i) : (int'(start_bin) - i);
                mb = mb & ((1 << N) - 1);
                mq.push_back(mb ^ (mb >> 1));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic ev;
            int   eo;
            ev = (mq.size() > 0);
            eo = ev ? mq[0] : last_code;
            chk("out_val", 32'(out_val), 32'(ev));
            chk("out", 32'(out), 32'(eo));
            chk("busy", 32'(busy), 32'(ev | done_exp));
            chk("done", 32'(done), 32'(done_exp));
            if (done === 1'b1) done_cnt++;
            if (out_val === 1'b1 && out_rdy) cap.push_back(int'(out));
        end
    end

    function automatic logic pick_rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 3) != 0);
            2:       return (k >= 3);
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_seq(input string name, input logic u, input logic [N-1:0] sb,
                           input logic [N-1:0] lm, input int mode, input bit hold_start);
        int d0;
        int k;
        cap.delete();
        d0        = done_cnt;
        up        = u;
        start_bin = sb;
        len_m1    = lm;
        start     = 1'b1;
        out_rdy   = pick_rdy(mode, 0);
        @(posedge clk); #2;
        start = hold_start;
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            out_rdy = pick_rdy(mode, k);
            @(posedge clk); #2;
            k++;
        end
        start   = 1'b0;
        out_rdy = 1'b0;
        chk({name, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, " code_count"}, 32'(cap.size()), 32'(int'(lm) + 1));
        for (int i = 1; i < cap.size(); i++)
            chk({name, " one_bit_step"}, 32'($countones(cap[i] ^ cap[i-1])), 32'd1);
    endtask

    task automatic check_cap(input string name, input int exp[$]);
        chk({name, " len"}, 32'(cap.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk({name, " code"}, 32'(cap[i]), 32'(exp[i]));
    endtask

    int e1[$];
    int e2[$];
    int e3[$];
    int e4[$];
    int e5[$];
    int e6[$];
    int d_before;

    initial begin
        e1 = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        e2 = '{1, 0, 8, 9};
        e3 = '{7, 5, 4};
        e4 = '{13};
        e5 = '{2, 6, 7, 5, 4, 12};
        e6 = '{8, 9, 11};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b0;
        chk_en = 1;
        @(negedge clk); #1;
        chk("reset out_val", 32'(out_val), 32'd0);
        chk("reset out", 32'(out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(posedge clk); #2;

        run_seq("full_up", 1'b1, 4'd0, 4'd15, 0, 0);
        check_cap("full_up", e1);

        run_seq("down_wrap", 1'b0, 4'd1, 4'd3, 0, 0);
        check_cap("down_wrap", e2);

        run_seq("backpressure", 1'b1, 4'd5, 4'd2, 2, 0);
        check_cap("backpressure", e3);

        run_seq("single", 1'b1, 4'd9, 4'd0, 0, 0);
        check_cap("single", e4);
        @(negedge clk); #1;
        chk("single busy_after_done", 32'(busy), 32'd0);
        @(posedge clk); #2;

        run_seq("start_held", 1'b1, 4'd3, 4'd5, 1, 1);
        check_cap("start_held", e5);

        // Abort after two transfers.
        d_before  = done_cnt;
        up        = 1'b1;
        start_bin = 4'd0;
        len_m1    = 4'd10;
        start     = 1'b1;
        @(posedge clk); #2;
        start   = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset   = 1'b1;
        out_rdy = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("abort out_val", 32'(out_val), 32'd0);
        chk("abort out", 32'(out), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #2;
        chk("abort no_done", 32'(done_cnt - d_before), 32'd0);

        run_seq("after_abort", 1'b0, 4'd15, 4'd2, 0, 0);
        check_cap("after_abort", e6);

        for (int r = 0; r < 25; r++) begin
            run_seq("random", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1, bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
